// File: rtl/squash_game_ctrl_if.sv
// Signal bundle between squash_game_ctrl and its surroundings (board buttons, solo_squash core).
// master drives buttons/core events and reads controls; slave is the controller itself.
interface squash_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               frame_tick;
  logic               start_n;
  logic               pause_btn_n;
  logic               hit;
  logic               miss;
  logic               new_game_n;
  logic               pause_n;
  logic [2:0]         state;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;

  modport master (
    output frame_tick, start_n, pause_btn_n, hit, miss,
    input  new_game_n, pause_n, state, lives, score
  );

  modport slave (
    input  frame_tick, start_n, pause_btn_n, hit, miss,
    output new_game_n, pause_n, state, lives, score
  );
endinterface

// File: rtl/squash_game_ctrl.sv
// Game-flow sequencer for solo_squash: attract/serve/play/pause/miss/over, button conditioning, lives and score.
// Optional macro SCORE_BCD_EN makes the score packed BCD instead of plain binary.
module squash_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int SCORE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  squash_game_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_MISS    = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LOAD  = 8'(MISS_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t             r_state;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [7:0]         r_timer;
  logic               r_new_game_n;
  logic               r_pause_n;
  logic               r_hit_flag;
  logic               r_miss_flag;

  logic r_start_s1, r_start_s2, r_start_prev, r_start_deb;
  logic r_pause_s1, r_pause_s2, r_pause_prev, r_pause_deb;

  logic w_start_press;
  logic w_pause_press;
  logic w_hit;
  logic w_miss;

  // Debounced level follows the per-frame sample only when two consecutive samples agree.
  // Reset leaves everything at 0 (pressed) so a button held through reset needs a release first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
      r_start_deb  <= 1'b0;
      r_pause_s1   <= 1'b0;
      r_pause_s2   <= 1'b0;
      r_pause_prev <= 1'b0;
      r_pause_deb  <= 1'b0;
    end else begin
      r_start_s1 <= bus.start_n;
      r_start_s2 <= r_start_s1;
      r_pause_s1 <= bus.pause_btn_n;
      r_pause_s2 <= r_pause_s1;
      if (bus.frame_tick) begin
        r_start_prev <= r_start_s2;
        r_pause_prev <= r_pause_s2;
        if (r_start_s2 == r_start_prev) r_start_deb <= r_start_s2;
        if (r_pause_s2 == r_pause_prev) r_pause_deb <= r_pause_s2;
      end
    end
  end

  assign w_start_press = bus.frame_tick && (r_start_s2 == r_start_prev) && !r_start_s2 && r_start_deb;
  assign w_pause_press = bus.frame_tick && (r_pause_s2 == r_pause_prev) && !r_pause_s2 && r_pause_deb;
  assign w_hit         = r_hit_flag  | bus.hit;
  assign w_miss        = r_miss_flag | bus.miss;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] v;
`ifdef SCORE_BCD_EN
    logic carry;
    v     = s;
    carry = 1'b1;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          v[i*4 +: 4] = 4'd0;
        end else begin
          v[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    // Carry out of the top digit means the score was all 9s: hold it.
    if (carry) v = s;
`else
    if (&s) v = s;
    else    v = s + {{(SCORE_W-1){1'b0}}, 1'b1};
`endif
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ATTRACT;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_timer      <= 8'd0;
      r_new_game_n <= 1'b0;
      r_pause_n    <= 1'b0;
      r_hit_flag   <= 1'b0;
      r_miss_flag  <= 1'b0;
    end else begin
      if (bus.frame_tick) begin
        r_hit_flag  <= 1'b0;
        r_miss_flag <= 1'b0;
      end else begin
        if (bus.hit)  r_hit_flag  <= 1'b1;
        if (bus.miss) r_miss_flag <= 1'b1;
      end

      case (r_state)
        ST_ATTRACT: begin
          if (w_start_press) begin
            r_state <= ST_SERVE;
            r_lives <= LIVES_INIT;
            r_score <= '0;
            r_timer <= SERVE_LOAD;
          end
        end
        ST_SERVE: begin
          if (bus.frame_tick) begin
            if (r_timer == 8'd0) begin
              r_state      <= ST_PLAY;
              r_new_game_n <= 1'b1;
              r_pause_n    <= 1'b1;
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (bus.frame_tick) begin
            // A miss swallows any hit from the same frame.
            if (w_miss) begin
              r_state   <= ST_MISS;
              r_pause_n <= 1'b0;
              r_timer   <= MISS_LOAD;
              if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
            end else begin
              if (w_pause_press) begin
                r_state   <= ST_PAUSED;
                r_pause_n <= 1'b0;
              end
              if (w_hit) r_score <= score_inc(r_score);
            end
          end
        end
        ST_PAUSED: begin
          if (w_start_press) begin
            r_state      <= ST_ATTRACT;
            r_new_game_n <= 1'b0;
            r_pause_n    <= 1'b0;
          end else if (w_pause_press) begin
            r_state   <= ST_PLAY;
            r_pause_n <= 1'b1;
          end
        end
        ST_MISS: begin
          if (bus.frame_tick) begin
            if (r_timer == 8'd0) begin
              if (r_lives == 3'd0) begin
                r_state <= ST_OVER;
              end else begin
                r_state      <= ST_SERVE;
                r_new_game_n <= 1'b0;
                r_timer      <= SERVE_LOAD;
              end
            end else begin
              r_timer <= r_timer - 8'd1;
            end
          end
        end
        ST_OVER: begin
          if (w_start_press) begin
            r_state      <= ST_SERVE;
            r_new_game_n <= 1'b0;
            r_lives      <= LIVES_INIT;
            r_score      <= '0;
            r_timer      <= SERVE_LOAD;
          end
        end
        default: begin
          r_state      <= ST_ATTRACT;
          r_new_game_n <= 1'b0;
          r_pause_n    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.lives      = r_lives;
  assign bus.score      = r_score;
  assign bus.new_game_n = r_new_game_n;
  assign bus.pause_n    = r_pause_n;

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed bench for squash_game_ctrl: serve/play/miss/over/pause flow, score saturation, async reset.
module tb_squash_game_ctrl;

`ifdef SCORE_BCD_EN
  localparam logic [7:0] TEN_VAL     = 8'h10;
  localparam logic [7:0] SAT_VAL     = 8'h99;
  localparam int         HITS_TO_SAT = 89;
`else
  localparam logic [7:0] TEN_VAL     = 8'h0A;
  localparam logic [7:0] SAT_VAL     = 8'hFF;
  localparam int         HITS_TO_SAT = 245;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  squash_game_ctrl_if #(.SCORE_W(8)) bus ();

  squash_game_ctrl #(
    .LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(30), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk); #1 bus.frame_tick = 1'b1;
      @(posedge clk); #1 bus.frame_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic hit_pulse();
    @(posedge clk); #1 bus.hit = 1'b1;
    @(posedge clk); #1 bus.hit = 1'b0;
  endtask

  task automatic miss_pulse();
    @(posedge clk); #1 bus.miss = 1'b1;
    @(posedge clk); #1 bus.miss = 1'b0;
  endtask

  task automatic hit_ticks(input int n);
    repeat (n) begin
      hit_pulse();
      tick_n(1);
    end
  endtask

  // Hold buttons low across two ticks (press lands on the second), then release and let syncs settle.
  task automatic press(input bit s, input bit p);
    if (s) bus.start_n = 1'b0;
    if (p) bus.pause_btn_n = 1'b0;
    clk_n(3);
    tick_n(2);
    bus.start_n     = 1'b1;
    bus.pause_btn_n = 1'b1;
    clk_n(3);
  endtask

  task automatic test_reset_state();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    checks++; if (bus.lives !== 3'd3) begin errors++; $display("FAIL rst_lives got %0d exp 3", bus.lives); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL rst_score got %h exp 00", bus.score); end
    checks++; if (bus.new_game_n !== 1'b0 || bus.pause_n !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl got ng=%b pn=%b exp 0 0", bus.new_game_n, bus.pause_n); end
  endtask

  task automatic test_start_serve();
    tick_n(2);
    press(1'b1, 1'b0);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_enter got %0d exp 1", bus.state); end
    tick_n(59);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL serve_hold got %0d exp 1", bus.state); end
    tick_n(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL play_enter got %0d exp 2", bus.state); end
    checks++; if (bus.new_game_n !== 1'b1 || bus.pause_n !== 1'b1) begin
      errors++; $display("FAIL play_ctrl got ng=%b pn=%b exp 1 1", bus.new_game_n, bus.pause_n); end
  endtask

  task automatic test_hit_miss();
    hit_ticks(5);
    checks++; if (bus.score !== 8'd5) begin errors++; $display("FAIL score5 got %h exp 05", bus.score); end
    hit_pulse();
    miss_pulse();
    tick_n(1);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL miss_state got %0d exp 4", bus.state); end
    checks++; if (bus.score !== 8'd5) begin errors++; $display("FAIL miss_score got %h exp 05", bus.score); end
    checks++; if (bus.lives !== 3'd2) begin errors++; $display("FAIL miss_lives got %0d exp 2", bus.lives); end
  endtask

  task automatic test_game_over();
    tick_n(29);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL miss_hold got %0d exp 4", bus.state); end
    tick_n(1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL reserve got %0d exp 1", bus.state); end
    tick_n(60);
    miss_pulse();
    tick_n(1);
    checks++; if (bus.lives !== 3'd1) begin errors++; $display("FAIL lives1 got %0d exp 1", bus.lives); end
    tick_n(90);
    miss_pulse();
    tick_n(1);
    checks++; if (bus.lives !== 3'd0) begin errors++; $display("FAIL lives0 got %0d exp 0", bus.lives); end
    tick_n(30);
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL over_state got %0d exp 5", bus.state); end
    checks++; if (bus.score !== 8'd5) begin errors++; $display("FAIL over_score got %h exp 05", bus.score); end
    checks++; if (bus.new_game_n !== 1'b1 || bus.pause_n !== 1'b0) begin
      errors++; $display("FAIL over_ctrl got ng=%b pn=%b exp 1 0", bus.new_game_n, bus.pause_n); end
    press(1'b1, 1'b0);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL restart_state got %0d exp 1", bus.state); end
    checks++; if (bus.lives !== 3'd3 || bus.score !== 8'd0) begin
      errors++; $display("FAIL restart_vals got lives=%0d score=%h exp 3 00", bus.lives, bus.score); end
  endtask

  task automatic test_pause();
    tick_n(60);
    press(1'b0, 1'b1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL pause_state got %0d exp 3", bus.state); end
    checks++; if (bus.pause_n !== 1'b0 || bus.new_game_n !== 1'b1) begin
      errors++; $display("FAIL pause_ctrl got ng=%b pn=%b exp 1 0", bus.new_game_n, bus.pause_n); end
    hit_ticks(4);
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL pause_score got %h exp 00", bus.score); end
    press(1'b0, 1'b1);
    checks++; if (bus.state !== 3'd2 || bus.pause_n !== 1'b1) begin
      errors++; $display("FAIL resume got state=%0d pn=%b exp 2 1", bus.state, bus.pause_n); end
    tick_n(2);
    press(1'b0, 1'b1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL repause got %0d exp 3", bus.state); end
    tick_n(2);
    press(1'b1, 1'b1);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL quit_state got %0d exp 0", bus.state); end
    checks++; if (bus.new_game_n !== 1'b0 || bus.pause_n !== 1'b0) begin
      errors++; $display("FAIL quit_ctrl got ng=%b pn=%b exp 0 0", bus.new_game_n, bus.pause_n); end
  endtask

  task automatic test_score_sat();
    tick_n(2);
    press(1'b1, 1'b0);
    tick_n(60);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL sat_play got %0d exp 2", bus.state); end
    hit_ticks(9);
    checks++; if (bus.score !== 8'h09) begin errors++; $display("FAIL score9 got %h exp 09", bus.score); end
    hit_ticks(1);
    checks++; if (bus.score !== TEN_VAL) begin errors++; $display("FAIL score10 got %h exp %h", bus.score, TEN_VAL); end
    hit_ticks(HITS_TO_SAT);
    checks++; if (bus.score !== SAT_VAL) begin errors++; $display("FAIL score_max got %h exp %h", bus.score, SAT_VAL); end
    hit_ticks(1);
    checks++; if (bus.score !== SAT_VAL) begin errors++; $display("FAIL score_sat got %h exp %h", bus.score, SAT_VAL); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2 reset = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.lives !== 3'd3 || bus.score !== 8'd0) begin
      errors++; $display("FAIL async_rst got state=%0d lives=%0d score=%h exp 0 3 00", bus.state, bus.lives, bus.score); end
    checks++; if (bus.new_game_n !== 1'b0 || bus.pause_n !== 1'b0) begin
      errors++; $display("FAIL async_rst_ctrl got ng=%b pn=%b exp 0 0", bus.new_game_n, bus.pause_n); end
    bus.start_n    = 1'b0;
    bus.frame_tick = 1'b1;
    clk_n(4);
    bus.frame_tick = 1'b0;
    @(negedge clk); reset = 1'b0;
    clk_n(3);
    tick_n(4);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL held_btn got %0d exp 0", bus.state); end
    bus.start_n = 1'b1;
    clk_n(3);
    tick_n(2);
    press(1'b1, 1'b0);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL repress got %0d exp 1", bus.state); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.start_n     = 1'b1;
    bus.pause_btn_n = 1'b1;
    bus.hit         = 1'b0;
    bus.miss        = 1'b0;
    clk_n(3);
    test_reset_state();
    @(negedge clk); reset = 1'b0;
    clk_n(3);
    test_start_serve();
    test_hit_miss();
    test_game_over();
    test_pause();
    test_score_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
